gate_deadtime_prot: RTL and testbench



---
 rtl/fcc_gate_pkg.sv | 22 ++
 rtl/gate_deadtime_prot_if.sv | 50 +++++
 rtl/deadtime_leg.sv | 87 ++++++++
 rtl/gate_deadtime_prot.sv | 107 ++++++++++
 tb/tb_gate_deadtime_prot.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fcc_gate_pkg.sv
// Shared types and constants for the flying-capacitor gate driver slice.
// Holds the per-channel state encoding, fault code bit positions and the
// default trip thresholds used by gate_deadtime_prot.
package fcc_gate_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOW_ON,
    ST_DT_UP,
    ST_HIGH_ON,
    ST_DT_DN
  } chan_state_e;

  localparam int unsigned FAULT_VOUT_BIT = 0;
  localparam int unsigned FAULT_VFC_BIT  = 1;

  localparam int          DEF_DEAD_CYCLES = 8;
  localparam int          DEF_TRIP_COUNT  = 3;
  localparam logic [11:0] DEF_VOUT_MAX    = 12'd3000;
  localparam logic [11:0] DEF_VFC_MAX     = 12'd2000;

endpackage

// File: rtl/gate_deadtime_prot_if.sv
// Signal bundle between the modulator/ADC side and the gate driver.
// The slave modport is the gate driver; the master modport is whoever
// feeds it commands and samples. Optional GATE_DEADTIME_RUNTIME_EN adds a
// runtime dead-time input.
interface gate_deadtime_prot_if;

`ifdef GATE_DEADTIME_RUNTIME_EN
  logic [7:0]  dead_cycles_i;
`endif
  logic        en_i;
  logic [1:0]  pwm_cmd_i;
  logic        sample_valid_i;
  logic [11:0] vout_i;
  logic [11:0] vfc_i;
  logic        clear_i;
  logic [3:0]  gate_o;
  logic        fault_o;
  logic [1:0]  fault_code_o;

  modport slave (
`ifdef GATE_DEADTIME_RUNTIME_EN
    input  dead_cycles_i,
`endif
    input  en_i,
    input  pwm_cmd_i,
    input  sample_valid_i,
    input  vout_i,
    input  vfc_i,
    input  clear_i,
    output gate_o,
    output fault_o,
    output fault_code_o
  );

  modport master (
`ifdef GATE_DEADTIME_RUNTIME_EN
    output dead_cycles_i,
`endif
    output en_i,
    output pwm_cmd_i,
    output sample_valid_i,
    output vout_i,
    output vfc_i,
    output clear_i,
    input  gate_o,
    input  fault_o,
    input  fault_code_o
  );

endinterface

// File: rtl/deadtime_leg.sv
// One converter cell: turns a single top-switch command into a
// complementary high/low gate pair with a dead-time gap between them.
// gate_o[0] = high side, gate_o[1] = low side, both registered.
module deadtime_leg
  import fcc_gate_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       force_off_i,
  input  logic       cmd_i,
  input  logic [7:0] dead_cycles_i,
  output logic [1:0] gate_o
);

  chan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gate_q, gate_d;
  logic [7:0]  load;

  // A dead time of 0 behaves as 1; the counter runs from N-1 down to 0
  assign load = (dead_cycles_i == 8'd0) ? 8'd0 : dead_cycles_i - 8'd1;

  // Next state, dead counter and gate pair computed from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gate_d  = 2'b00;

    unique case (state_q)
      ST_OFF: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else if (!cmd_i)   state_d = ST_LOW_ON;
      end
      ST_LOW_ON: begin
        if (cmd_i) begin
          state_d = ST_DT_UP;
          cnt_d   = load;
        end
      end
      ST_DT_UP: begin
        if (!cmd_i)                state_d = ST_LOW_ON;
        else if (cnt_q == 8'd0)    state_d = ST_HIGH_ON;
        else                       cnt_d   = cnt_q - 8'd1;
      end
      ST_HIGH_ON: begin
        if (!cmd_i) begin
          state_d = ST_DT_DN;
          cnt_d   = load;
        end
      end
      ST_DT_DN: begin
        if (cmd_i)                 state_d = ST_HIGH_ON;
        else if (cnt_q == 8'd0)    state_d = ST_LOW_ON;
        else                       cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_OFF;
    endcase

    // Forced off: if the high side was just on, OFF must still wait out a
    // full dead time before the low side may come back; from the low side
    // no gap is owed.
    if (force_off_i) begin
      state_d = ST_OFF;
      if (state_q == ST_HIGH_ON)                         cnt_d = load;
      else if (state_q inside {ST_LOW_ON, ST_DT_UP})     cnt_d = 8'd0;
    end

    if (state_d == ST_LOW_ON)       gate_d = 2'b10;
    else if (state_d == ST_HIGH_ON) gate_d = 2'b01;
  end

  // State, counter and gate output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      gate_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/gate_deadtime_prot.sv
// Gate driver for the 3-level flying-capacitor stage: two dead-time legs
// plus an over-voltage trip on Vout/Vfc that latches every gate off until
// a software clear. Optional macro GATE_DEADTIME_RUNTIME_EN takes the dead
// time from the dead_cycles_i bus input instead of DEAD_CYCLES.
module gate_deadtime_prot
  import fcc_gate_pkg::*;
#(
  parameter int          DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter logic [11:0] VOUT_MAX    = DEF_VOUT_MAX,
  parameter logic [11:0] VFC_MAX     = DEF_VFC_MAX,
  parameter int          TRIP_COUNT  = DEF_TRIP_COUNT
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gate_deadtime_prot_if.slave  bus
);

  localparam logic [3:0] TRIP_LIMIT = 4'(TRIP_COUNT);

  logic [7:0] dead_cycles;
  logic [3:0] gate;
  logic       force_off;
  logic       vout_over, vfc_over;
  logic       trip_vout, trip_vfc;
  logic [3:0] cnt_vout_q, cnt_vout_d;
  logic [3:0] cnt_vfc_q, cnt_vfc_d;
  logic       last_ok_q, last_ok_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;

`ifdef GATE_DEADTIME_RUNTIME_EN
  assign dead_cycles = bus.dead_cycles_i;
`else
  assign dead_cycles = 8'(DEAD_CYCLES);
`endif

  // Registered fault kills both legs; the trip therefore reaches the gates
  // one cycle after fault_o rises.
  assign force_off = !bus.en_i || fault_q;
  assign vout_over = bus.vout_i > VOUT_MAX;
  assign vfc_over  = bus.vfc_i > VFC_MAX;

  for (genvar k = 0; k < 2; k++) begin : g_leg
    deadtime_leg u_leg (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .force_off_i   (force_off),
      .cmd_i         (bus.pwm_cmd_i[k]),
      .dead_cycles_i (dead_cycles),
      .gate_o        (gate[2*k +: 2])
    );
  end

  // Trip counters, fault latch and clear qualification; a trip beats a clear
  always_comb begin
    cnt_vout_d = cnt_vout_q;
    cnt_vfc_d  = cnt_vfc_q;
    last_ok_d  = last_ok_q;
    fault_d    = fault_q;
    code_d     = code_q;
    trip_vout  = 1'b0;
    trip_vfc   = 1'b0;

    if (bus.sample_valid_i) begin
      if (!vout_over)                     cnt_vout_d = 4'd0;
      else if (cnt_vout_q != TRIP_LIMIT)  cnt_vout_d = cnt_vout_q + 4'd1;
      if (!vfc_over)                      cnt_vfc_d  = 4'd0;
      else if (cnt_vfc_q != TRIP_LIMIT)   cnt_vfc_d  = cnt_vfc_q + 4'd1;
      last_ok_d = !vout_over && !vfc_over;
      trip_vout = cnt_vout_d == TRIP_LIMIT;
      trip_vfc  = cnt_vfc_d == TRIP_LIMIT;
    end

    if (trip_vout || trip_vfc) begin
      fault_d = 1'b1;
      if (trip_vout) code_d[FAULT_VOUT_BIT] = 1'b1;
      if (trip_vfc)  code_d[FAULT_VFC_BIT]  = 1'b1;
    end else if (bus.clear_i && last_ok_d) begin
      fault_d    = 1'b0;
      code_d     = 2'b00;
      cnt_vout_d = 4'd0;
      cnt_vfc_d  = 4'd0;
    end
  end

  // Trip/fault registers; last_ok starts set since nothing over-limit is seen
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_vout_q <= 4'd0;
      cnt_vfc_q  <= 4'd0;
      last_ok_q  <= 1'b1;
      fault_q    <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      cnt_vout_q <= cnt_vout_d;
      cnt_vfc_q  <= cnt_vfc_d;
      last_ok_q  <= last_ok_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
    end
  end

  assign bus.gate_o       = gate;
  assign bus.fault_o      = fault_q;
  assign bus.fault_code_o = code_q;

endmodule

// File: tb/tb_gate_deadtime_prot.sv
// Directed bench for gate_deadtime_prot: dead-time timing, short pulses,
// enable forcing, Vout/Vfc trips, clear qualification and async reset.
// Expected outputs are queued per step and popped after each clock edge.
module tb_gate_deadtime_prot;

  typedef struct {
    string      tag;
    logic [3:0] gate;
    logic       fault;
    logic [1:0] code;
  } exp_t;

  logic clk;
  logic rstN;
  int   checkCount;
  int   errorCount;
  exp_t sbQ[$];

  gate_deadtime_prot_if bus ();

  gate_deadtime_prot #(
    .DEAD_CYCLES (8),
    .VOUT_MAX    (12'd3000),
    .VFC_MAX     (12'd2000),
    .TRIP_COUNT  (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shoot-through watch on both pairs every cycle
  always @(negedge clk) begin
    if (rstN) begin
      checkCount++;
      assert (((bus.gate_o[1:0] == 2'b11) || (bus.gate_o[3:2] == 2'b11)) === 1'b0)
      else begin
        errorCount++;
        $error("[TB] FAIL pair_overlap: observed gate=%b required no 11 pair", bus.gate_o);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checkCount++;
    if (sbQ.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL scoreboard_empty: observed no entry required one");
    end else begin
      e = sbQ.pop_front();
      assert ({bus.gate_o, bus.fault_o, bus.fault_code_o} === {e.gate, e.fault, e.code})
      else begin
        errorCount++;
        $error("[TB] FAIL %s: observed gate=%b fault=%b code=%b required gate=%b fault=%b code=%b",
               e.tag, bus.gate_o, bus.fault_o, bus.fault_code_o, e.gate, e.fault, e.code);
      end
    end
  endtask

  task automatic expectOut(string tag, logic [3:0] g, logic f, logic [1:0] c);
    exp_t e;
    e.tag = tag; e.gate = g; e.fault = f; e.code = c;
    sbQ.push_back(e);
  endtask

  // Inputs are already set by the caller; queue the expectation, clock once, compare
  task automatic applyStimulus(string tag, logic [3:0] g, logic f, logic [1:0] c);
    expectOut(tag, g, f, c);
    tick();
    checkOutput();
  endtask

  // One ADC strobe cycle followed by one quiet cycle
  task automatic sample(string tag, logic [11:0] vo, logic [11:0] vf,
                        logic [3:0] g1, logic f1, logic [1:0] c1,
                        logic [3:0] g2, logic f2, logic [1:0] c2);
    bus.sample_valid_i = 1'b1;
    bus.vout_i = vo;
    bus.vfc_i  = vf;
    applyStimulus({tag, "_strobe"}, g1, f1, c1);
    bus.sample_valid_i = 1'b0;
    applyStimulus({tag, "_after"}, g2, f2, c2);
  endtask

  task automatic pulseClear(string tag, logic [3:0] g, logic f, logic [1:0] c);
    bus.clear_i = 1'b1;
    applyStimulus(tag, g, f, c);
    bus.clear_i = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN = 1'b0;
`ifdef GATE_DEADTIME_RUNTIME_EN
    bus.dead_cycles_i = 8'd8;
`endif
    bus.en_i = 1'b0;
    bus.pwm_cmd_i = 2'b00;
    bus.sample_valid_i = 1'b0;
    bus.vout_i = 12'd0;
    bus.vfc_i = 12'd0;
    bus.clear_i = 1'b0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    expectOut("reset_state", 4'b0000, 1'b0, 2'b00);
    checkOutput();
    rstN = 1'b1;

    bus.en_i = 1'b1;
    applyStimulus("en_low_on", 4'b1010, 1'b0, 2'b00);

    $display("[TB] dead time rising edge");
    bus.pwm_cmd_i = 2'b01;
    applyStimulus("dtup_low_off", 4'b1000, 1'b0, 2'b00);
    for (int i = 2; i <= 8; i++) applyStimulus("dtup_hold", 4'b1000, 1'b0, 2'b00);
    applyStimulus("high_on_9", 4'b1001, 1'b0, 2'b00);

    $display("[TB] dead time falling edge");
    bus.pwm_cmd_i = 2'b00;
    for (int i = 1; i <= 8; i++) applyStimulus("dtdn_hold", 4'b1000, 1'b0, 2'b00);
    applyStimulus("dtdn_low_on", 4'b1010, 1'b0, 2'b00);

    $display("[TB] short pulse");
    bus.pwm_cmd_i = 2'b01;
    for (int i = 1; i <= 4; i++) applyStimulus("pulse_dt", 4'b1000, 1'b0, 2'b00);
    bus.pwm_cmd_i = 2'b00;
    applyStimulus("pulse_low_back", 4'b1010, 1'b0, 2'b00);

    $display("[TB] enable forcing");
    bus.en_i = 1'b0;
    applyStimulus("en_off", 4'b0000, 1'b0, 2'b00);
    bus.en_i = 1'b1;
    applyStimulus("en_resume", 4'b1010, 1'b0, 2'b00);

    // High side forced off must still see a full dead time before low returns
    bus.pwm_cmd_i = 2'b01;
    for (int i = 1; i <= 8; i++) applyStimulus("dtup_again", 4'b1000, 1'b0, 2'b00);
    applyStimulus("high_on_again", 4'b1001, 1'b0, 2'b00);
    bus.en_i = 1'b0;
    applyStimulus("en_off_high", 4'b0000, 1'b0, 2'b00);
    bus.en_i = 1'b1;
    bus.pwm_cmd_i = 2'b00;
    for (int i = 1; i <= 7; i++) applyStimulus("high_dead_guard", 4'b1000, 1'b0, 2'b00);
    applyStimulus("low_after_guard", 4'b1010, 1'b0, 2'b00);

    $display("[TB] vout trip");
    sample("vout_3001_a", 12'd3001, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_2999",   12'd2999, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_3001_b", 12'd3001, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_eq_max", 12'd3000, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_over_1", 12'd3001, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_over_2", 12'd3001, 12'd1000, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("vout_trip",   12'd3001, 12'd1000, 4'b1010, 1'b1, 2'b01, 4'b0000, 1'b1, 2'b01);
    pulseClear("clear_blocked_vout", 4'b0000, 1'b1, 2'b01);
    sample("vout_recover", 12'd1000, 12'd1000, 4'b0000, 1'b1, 2'b01, 4'b0000, 1'b1, 2'b01);
    pulseClear("clear_ok", 4'b0000, 1'b0, 2'b00);
    applyStimulus("restart_low", 4'b1010, 1'b0, 2'b00);

    $display("[TB] dual trip");
    sample("dual_1",    12'd3001, 12'd2001, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("dual_2",    12'd3001, 12'd2001, 4'b1010, 1'b0, 2'b00, 4'b1010, 1'b0, 2'b00);
    sample("dual_trip", 12'd3001, 12'd2001, 4'b1010, 1'b1, 2'b11, 4'b0000, 1'b1, 2'b11);

    $display("[TB] clear qualification");
    bus.pwm_cmd_i = 2'b01;
    sample("vfc_2500", 12'd1000, 12'd2500, 4'b0000, 1'b1, 2'b11, 4'b0000, 1'b1, 2'b11);
    pulseClear("clear_blocked_vfc", 4'b0000, 1'b1, 2'b11);
    sample("vfc_1500", 12'd1000, 12'd1500, 4'b0000, 1'b1, 2'b11, 4'b0000, 1'b1, 2'b11);
    pulseClear("clear_after_ok", 4'b0000, 1'b0, 2'b00);
    for (int i = 1; i <= 3; i++) applyStimulus("off_while_cmd1", 4'b1000, 1'b0, 2'b00);
    bus.pwm_cmd_i = 2'b00;
    applyStimulus("low_after_clear", 4'b1010, 1'b0, 2'b00);

    $display("[TB] reset during dead time");
    bus.pwm_cmd_i = 2'b01;
    applyStimulus("dtup_pre_reset", 4'b1000, 1'b0, 2'b00);
    applyStimulus("dtup_pre_reset2", 4'b1000, 1'b0, 2'b00);
    rstN = 1'b0;
    #1;
    expectOut("reset_async", 4'b0000, 1'b0, 2'b00);
    checkOutput();
    applyStimulus("reset_held", 4'b0000, 1'b0, 2'b00);
    rstN = 1'b1;
    applyStimulus("reset_off_leg0", 4'b1000, 1'b0, 2'b00);
    bus.pwm_cmd_i = 2'b00;
    applyStimulus("reset_cnt_zero", 4'b1010, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
